// File: rtl/uart_pkg.sv
// Shared UART package: FSM state encoding, baud constants for a 50 MHz clock
// and the default frame width.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_REST   = 3'd5
    } rx_state_e;

    // Baud counter terminal counts at 50 MHz (period = value + 1 cycles).
    localparam int BPS_115200 = 433;
    localparam int BPS_9600   = 5207;

    localparam int DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte-out interface of the UART receiver.
// Config macro: UART_RX_PARITY_EN adds parity_err.
//   rx_data    last good byte, held until the next good frame
//   rx_done    1-cycle strobe: rx_data updated
//   frame_err  1-cycle strobe: stop bit sampled low
//   parity_err 1-cycle strobe: parity mismatch (parity build only)
// Strobe semantics: no handshake back-pressure; each strobe is a single-cycle
// qualifier, at most one per frame, and the consumer must take it that cycle.
// master = receiver, slave = byte consumer.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS_DEFAULT
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (output rx_data, rx_done, frame_err, parity_err);
    modport slave  (input  rx_data, rx_done, frame_err, parity_err);
`else
    modport master (output rx_data, rx_done, frame_err);
    modport slave  (input  rx_data, rx_done, frame_err);
`endif
endinterface

// File: rtl/rx_edge_sync.sv
// Synchroniser for the asynchronous rx pin plus a registered falling-edge
// detector.
//   clk, rst_n    clock, async active-low reset
//   rx_pin_i      raw serial line, idle high
//   line_s_o      synchronised line level
//   fall_pulse_o  1-cycle pulse, one cycle after line_s goes 1 -> 0
module rx_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_pin_i,
    output logic line_s_o,
    output logic fall_pulse_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   fall_q;

    // Flops reset to the idle-high level so no edge appears out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            fall_q <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    assign line_s_o     = sync_q[SYNC_STAGES-1];
    assign fall_pulse_o = fall_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer. Detects the start bit, runs the external baud
// counter through rx_count_sig and samples each bit on its mid-bit bps_clk
// pulse: start, DATA_BITS data LSB-first, optional parity, stop.
// Config macro: UART_RX_PARITY_EN (parity bit + parity_err strobe).
//   clk, rst_n    50 MHz clock, async active-low reset
//   rx_en         receive enable; low aborts to IDLE
//   rx_pin        asynchronous serial line, idle high
//   bps_clk       mid-bit pulse from the baud counter
//   rx_count_sig  run enable to the baud counter (high START..STOP)
//   dbg_state_o   current FSM state
//   rx_if         byte output (rx_data / rx_done / frame_err [/ parity_err])
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_en,
    input  logic      rx_pin,
    input  logic      bps_clk,
    output logic      rx_count_sig,
    output rx_state_e dbg_state_o,
    uart_rx_ctrl_if.master rx_if
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic line_s;
    logic fall_pulse;

    rx_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_pin_i     (rx_pin),
        .line_s_o     (line_s),
        .fall_pulse_o (fall_pulse)
    );

    rx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [2:0]           bit_q, bit_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 par_bad_q, par_bad_d;
`else
    logic                 unused_parity_cfg;
    assign unused_parity_cfg = ^PARITY_ODD;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            data_q    <= '0;
            bit_q     <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            bit_q     <= bit_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        data_d    = data_q;
        bit_d     = bit_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        if (!rx_en) begin
            // Abort: partial byte is discarded, no strobe.
            state_d = ST_IDLE;
            shift_d = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_pulse) state_d = ST_START;
                end
                ST_START: begin
                    if (bps_clk) begin
                        if (line_s) begin
                            state_d = ST_IDLE;     // glitch, not a start bit
                        end else begin
                            state_d = ST_DATA;
                            bit_d   = '0;
                            shift_d = '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (bps_clk) begin
                        shift_d = {line_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bps_clk) begin
                        par_bad_d = line_s != ((^shift_q) ^ PARITY_ODD[0]);
                        state_d   = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bps_clk) begin
                        if (!line_s) begin
                            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            perr_d = 1'b1;
`endif
                        end else begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end
                        state_d = ST_REST;
                    end
                end
                // One cycle with rx_count_sig low lets the baud counter clear.
                ST_REST: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rx_count_sig = (state_q == ST_START) || (state_q == ST_DATA) ||
                          (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign dbg_state_o  = state_q;

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_done    = done_q;
    assign rx_if.frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int BPS        = BPS_115200;
  localparam int BIT_CYC    = BPS + 1;
  localparam int PARITY_ODD = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  logic      rx_en;
  logic      rx_pin;
  logic      bps_clk;
  logic      rx_count_sig;
  rx_state_e dbg_state;

  uart_rx_ctrl_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2), .PARITY_ODD(PARITY_ODD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_en        (rx_en),
    .rx_pin       (rx_pin),
    .bps_clk      (bps_clk),
    .rx_count_sig (rx_count_sig),
    .dbg_state_o  (dbg_state),
    .rx_if        (rx_if)
  );

  // baud counter: free-runs while enabled, pulses at mid-bit
  int unsigned bcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= 0;
    else if (!rx_count_sig) bcnt <= 0;
    else if (bcnt == BPS) bcnt <= 0;
    else bcnt <= bcnt + 1;
  end
  assign bps_clk = rx_count_sig && (bcnt == BPS / 2);

  // ---------------- scoreboard ----------------
  // event encoding: {kind[1:0], data[7:0]}; kind 1=done, 2=frame_err, 3=parity_err
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic [7:0] last_good;
  int checks = 0;
  int errors = 0;
  int wide_cnt = 0;
  int multi_cnt = 0;
  int cs_bad = 0;

  logic [2:0] strobes;
  logic [2:0] prev_strobes = 3'b000;
  logic       prev_cs = 1'b0;

  always @(negedge clk) begin
    strobes[0] = rx_if.rx_done;
    strobes[1] = rx_if.frame_err;
`ifdef UART_RX_PARITY_EN
    strobes[2] = rx_if.parity_err;
`else
    strobes[2] = 1'b0;
`endif
    if ($countones(strobes) > 1) multi_cnt++;
    if (strobes != 3'b000 && prev_strobes != 3'b000) wide_cnt++;
    if (strobes != 3'b000 && (rx_count_sig !== 1'b0 || prev_cs !== 1'b1)) cs_bad++;
    if (strobes[0]) obs_q.push_back({2'd1, rx_if.rx_data});
    if (strobes[1]) obs_q.push_back({2'd2, 8'h00});
    if (strobes[2]) obs_q.push_back({2'd3, 8'h00});
    prev_strobes = strobes;
    prev_cs = rx_count_sig;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: frame outcome straight from the line-level rules
  function automatic logic [9:0] model_frame(input logic [7:0] d, input bit stop, input bit par);
    if (!stop) return {2'd2, 8'h00};
`ifdef UART_RX_PARITY_EN
    if (par != ((^d) ^ PARITY_ODD[0])) return {2'd3, 8'h00};
`endif
    return {2'd1, d};
  endfunction

  // ---------------- driver ----------------
  task automatic hold_bit(input logic v, input bit meas);
    rx_pin = v;
    for (int c = 0; c < BIT_CYC; c++) begin
      @(negedge clk);
      if (meas && c == 2) check("lat_pre", 32'(rx_count_sig), 32'd0);
      if (meas && c == 3) check("lat_hit", 32'(rx_count_sig), 32'd1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par, input bit meas);
    @(negedge clk);
    hold_bit(1'b0, meas);
    for (int i = 0; i < 8; i++) hold_bit(d[i], 1'b0);
`ifdef UART_RX_PARITY_EN
    hold_bit(par, 1'b0);
`endif
    hold_bit(stop, 1'b0);
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_event"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
    check({tag, "_data"}, 32'(rx_if.rx_data), 32'(last_good));
  endtask

  task automatic run_frame(input logic [7:0] d, input bit stop, input bit par,
                           input bit meas, input string tag);
    logic [9:0] e;
    e = model_frame(d, stop, par);
    exp_q.push_back(e);
    if (e[9:8] == 2'd1) last_good = d;
    send_frame(d, stop, par, meas);
    repeat (5) @(negedge clk);
    compare_events(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] rd;
    bit rs, rp;
    rst_n = 1'b0;
    rx_en = 1'b1;
    rx_pin = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(rx_if.rx_data), 32'h0);
    check("rst_done", 32'(rx_if.rx_done), 32'h0);
    check("rst_ferr", 32'(rx_if.frame_err), 32'h0);
    check("rst_cs", 32'(rx_count_sig), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // good frame, with start latency measurement
    run_frame(8'hA5, 1'b1, ^8'hA5, 1'b1, "a5");

    // short low glitch: false start
    rx_pin = 1'b0;
    repeat (100) @(negedge clk);
    rx_pin = 1'b1;
    repeat (600) @(negedge clk);
    check("glitch_cs", 32'(rx_count_sig), 32'h0);
    compare_events("glitch");

    // framing error keeps previous byte
    run_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, "ferr");

    // abort during data bit 3
    fork
      send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0);
      begin
        repeat (4 * BIT_CYC + 200) @(negedge clk);
        check("abort_pre", 32'(rx_count_sig), 32'h1);
        rx_en = 1'b0;
        @(negedge clk);
        check("abort_cs", 32'(rx_count_sig), 32'h0);
      end
    join
    rx_en = 1'b1;
    repeat (10) @(negedge clk);
    compare_events("abort");
    run_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, "5a");

    // asynchronous reset mid-frame
    fork
      send_frame(8'h77, 1'b1, ^8'h77, 1'b0);
      begin
        repeat (3 * BIT_CYC) @(negedge clk);
        check("rstm_pre", 32'(rx_count_sig), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("rstm_cs", 32'(rx_count_sig), 32'h0);
        check("rstm_data", 32'(rx_if.rx_data), 32'h0);
        check("rstm_state", 32'(dbg_state), 32'(ST_IDLE));
      end
    join
    last_good = 8'h00;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    compare_events("rstm");
    run_frame(8'hFF, 1'b1, ^8'hFF, 1'b0, "ff");

`ifdef UART_RX_PARITY_EN
    run_frame(8'h0F, 1'b1, 1'b1, 1'b0, "par_bad");
    run_frame(8'h0F, 1'b1, 1'b0, 1'b0, "par_ok");
`endif

    // randomized frames
    for (int n = 0; n < 4; n++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = (^rd) ^ PARITY_ODD[0] ^ ($urandom_range(0, 3) == 0);
      run_frame(rd, rs, rp, 1'b0, "rand");
    end

    check("strobe_width", 32'(wide_cnt), 32'h0);
    check("strobe_excl", 32'(multi_cnt), 32'h0);
    check("strobe_cs", 32'(cs_bad), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
